// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller pipeline-side signal bundle
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_reg1_addr;
    logic                  id_reg1_read;
    logic [REG_ADDR_W-1:0] id_reg2_addr;
    logic                  id_reg2_read;
    logic [REG_ADDR_W-1:0] ex_wb_addr;
    logic                  ex_reg_write;
    logic                  ex_is_load;
    logic                  ex_branch_taken;
    logic                  mem_req;
    logic                  mem_shared;
    logic                  mem_ack;
    logic                  perf_clr;
    logic                  pc_stall;
    logic                  ifid_stall;
    logic                  ifid_flush;
    logic                  idex_stall;
    logic                  idex_flush;
    logic                  exmem_stall;
    logic                  memwb_flush;
    logic                  mem_timeout;
    logic [CNT_W-1:0]      stall_count;
    logic [1:0]            ctrl_state;

    // pipeline side: drives stage status, receives hold/bubble controls
    modport master (
        output id_reg1_addr, id_reg1_read, id_reg2_addr, id_reg2_read,
               ex_wb_addr, ex_reg_write, ex_is_load, ex_branch_taken,
               mem_req, mem_shared, mem_ack, perf_clr,
        input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, memwb_flush, mem_timeout, stall_count, ctrl_state
    );

    // hazard controller side
    modport slave (
        input  id_reg1_addr, id_reg1_read, id_reg2_addr, id_reg2_read,
               ex_wb_addr, ex_reg_write, ex_is_load, ex_branch_taken,
               mem_req, mem_shared, mem_ack, perf_clr,
        output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, memwb_flush, mem_timeout, stall_count, ctrl_state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline stall/flush scheduler
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W     = 4,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int WAIT_CNT_W     = 4,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_MEM_WAIT = 2'b01,
        S_TIMEOUT  = 2'b10
    } state_t;

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]      r_stall_count;

    logic w_loaduse;
    logic w_pc_stall, w_ifid_stall, w_ifid_flush, w_idex_stall, w_idex_flush;
    logic w_exmem_stall, w_memwb_flush, w_mem_timeout;

    assign w_loaduse = bus.ex_is_load & bus.ex_reg_write &
                       ((bus.id_reg1_read & (bus.ex_wb_addr == bus.id_reg1_addr)) |
                        (bus.id_reg2_read & (bus.ex_wb_addr == bus.id_reg2_addr)));

    // zero-latency stall/flush decode from current state and stage status
    always_comb begin
        w_pc_stall    = 1'b0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_stall  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_stall = 1'b0;
        w_memwb_flush = 1'b0;
        w_mem_timeout = 1'b0;
        if (!rst) begin
            if (r_state == S_TIMEOUT) begin
                // freeze front end but let the stuck access drain out of MEM
                w_pc_stall    = 1'b1;
                w_ifid_stall  = 1'b1;
                w_idex_stall  = 1'b1;
                w_memwb_flush = 1'b1;
                w_mem_timeout = 1'b1;
            end else if (!bus.mem_ack && (bus.mem_req || r_state == S_MEM_WAIT)) begin
                // outstanding access: hold everything up to MEM, bubble into WB
                w_pc_stall    = 1'b1;
                w_ifid_stall  = 1'b1;
                w_idex_stall  = 1'b1;
                w_exmem_stall = 1'b1;
                w_memwb_flush = 1'b1;
            end else if (bus.ex_branch_taken) begin
                // squash wrong-path instructions; PC takes the target
                w_ifid_flush = 1'b1;
                w_idex_flush = 1'b1;
            end else if (w_loaduse) begin
                w_pc_stall   = 1'b1;
                w_ifid_stall = 1'b1;
                w_idex_flush = 1'b1;
            end else if (bus.mem_req && bus.mem_ack && bus.mem_shared) begin
                // fetch lost the shared RAM this cycle, so its word is garbage
                w_pc_stall   = 1'b1;
                w_ifid_flush = 1'b1;
            end
        end
    end

    // state, wait counter and saturating stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= '0;
            r_stall_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.mem_req && !bus.mem_ack) begin
                        r_state    <= S_MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                S_MEM_WAIT: begin
                    if (bus.mem_ack) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                        if (r_wait_cnt == WAIT_LAST) begin
                            r_state <= S_TIMEOUT;
                        end
                    end
                end
                S_TIMEOUT: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase

            if (bus.perf_clr) begin
                r_stall_count <= '0;
            end else if (w_pc_stall && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign bus.pc_stall    = w_pc_stall;
    assign bus.ifid_stall  = w_ifid_stall;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_stall  = w_idex_stall;
    assign bus.idex_flush  = w_idex_flush;
    assign bus.exmem_stall = w_exmem_stall;
    assign bus.memwb_flush = w_memwb_flush;
    assign bus.mem_timeout = w_mem_timeout;
    assign bus.stall_count = r_stall_count;
    assign bus.ctrl_state  = r_state;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and randomized checks against a behavioural model
module tb_pipeline_hazard_ctrl;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(4), .CNT_W(16)) bus ();

    pipeline_hazard_ctrl #(
        .REG_ADDR_W(4), .TIMEOUT_CYCLES(TO), .WAIT_CNT_W(4), .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // model: is an access outstanding, how many wait cycles elapsed, forced release pending
    bit m_waiting = 0;
    int m_waited  = 0;
    bit m_release = 0;
    int m_count   = 0;

    // expected {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush, mem_timeout}
    function automatic logic [7:0] model_out();
        bit lu;
        if (rst) return 8'h00;
        if (m_release) return 8'b1101_0011;
        if (!bus.mem_ack && (bus.mem_req || m_waiting)) return 8'b1101_0110;
        lu = bus.ex_is_load && bus.ex_reg_write &&
             ((bus.id_reg1_read && bus.ex_wb_addr == bus.id_reg1_addr) ||
              (bus.id_reg2_read && bus.ex_wb_addr == bus.id_reg2_addr));
        if (bus.ex_branch_taken) return 8'b0010_1000;
        if (lu) return 8'b1100_1000;
        if (bus.mem_req && bus.mem_ack && bus.mem_shared) return 8'b1010_0000;
        return 8'h00;
    endfunction

    function automatic logic [1:0] model_state();
        if (m_release) return 2'b10;
        if (m_waiting) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_advance(input logic pc_stall_exp);
        if (rst) begin
            m_waiting = 0; m_waited = 0; m_release = 0; m_count = 0;
            return;
        end
        if (bus.perf_clr) m_count = 0;
        else if (pc_stall_exp && m_count < 65535) m_count = m_count + 1;
        if (m_release) begin
            m_release = 0;
        end else if (m_waiting) begin
            if (bus.mem_ack) m_waiting = 0;
            else begin
                m_waited = m_waited + 1;
                if (m_waited == TO) begin m_waiting = 0; m_release = 1; end
            end
        end else if (bus.mem_req && !bus.mem_ack) begin
            m_waiting = 1; m_waited = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.id_reg1_addr = '0; bus.id_reg1_read = 0;
        bus.id_reg2_addr = '0; bus.id_reg2_read = 0;
        bus.ex_wb_addr = '0;   bus.ex_reg_write = 0;
        bus.ex_is_load = 0;    bus.ex_branch_taken = 0;
        bus.mem_req = 0; bus.mem_shared = 0; bus.mem_ack = 0; bus.perf_clr = 0;
    endtask

    // inputs already applied #1 after a rising edge; sample at the falling edge
    task automatic step(input string tag);
        logic [7:0] eo;
        logic [7:0] ob;
        #4;
        eo = model_out();
        ob = {bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.idex_stall,
              bus.idex_flush, bus.exmem_stall, bus.memwb_flush, bus.mem_timeout};
        check({tag, "_outs"}, 32'(ob), 32'(eo));
        check({tag, "_state"}, 32'(bus.ctrl_state), 32'(model_state()));
        check({tag, "_count"}, 32'(bus.stall_count), 32'(m_count));
        model_advance(eo[7]);
        @(posedge clk);
        #1;
    endtask

    task automatic set_loaduse();
        bus.ex_is_load = 1; bus.ex_reg_write = 1; bus.ex_wb_addr = 4'd3;
        bus.id_reg1_addr = 4'd3; bus.id_reg1_read = 1;
    endtask

    int base;

    initial begin
        clear_inputs();
        rst = 1;
        @(posedge clk); #1;
        step("reset");
        rst = 0;
        step("idle");

        // load-use hit then miss
        base = m_count;
        set_loaduse();
        step("loaduse_hit");
        check("loaduse_pc_stall_exact", 32'(bus.stall_count), 32'(base + 1));
        bus.id_reg1_read = 0;
        step("loaduse_noread");
        clear_inputs();

        // branch beats load-use
        set_loaduse(); bus.ex_branch_taken = 1;
        step("branch_over_lu");
        clear_inputs();
        step("post_branch");

        // multi-cycle shared access with ack on cycle 3
        base = m_count;
        bus.mem_req = 1; bus.mem_shared = 1;
        for (int c = 0; c < 4; c++) begin
            bus.mem_ack = (c == 3);
            step("shared_multi");
        end
        clear_inputs();
        check("shared_multi_delta", 32'(bus.stall_count), 32'(base + 4));
        check("shared_multi_idle", 32'(bus.ctrl_state), 32'd0);
        step("shared_multi_after");

        // timeout
        base = m_count;
        bus.mem_req = 1;
        for (int c = 0; c < 17; c++) step("timeout_seq");
        clear_inputs();
        check("timeout_delta", 32'(bus.stall_count), 32'(base + 17));
        check("timeout_idle", 32'(bus.ctrl_state), 32'd0);
        step("timeout_after");

        // reset at 5th MEM_WAIT cycle
        bus.mem_req = 1;
        for (int c = 0; c < 5; c++) step("rst_wait");
        rst = 1;
        step("rst_mid_wait");
        rst = 0;
        check("rst_count_zero", 32'(bus.stall_count), 32'd0);
        check("rst_state_idle", 32'(bus.ctrl_state), 32'd0);
        clear_inputs();
        step("rst_after");

        // perf_clr concurrent with stall
        set_loaduse(); step("pre_clr");
        bus.perf_clr = 1; step("clr_with_stall");
        clear_inputs();
        check("clr_count_zero", 32'(bus.stall_count), 32'd0);

        // single-cycle non-shared access
        bus.mem_req = 1; bus.mem_ack = 1;
        step("single_nonshared");
        clear_inputs();

        // randomized traffic, two ack densities so timeouts occur
        for (int i = 0; i < 1200; i++) begin
            int ack_pct;
            ack_pct = (i < 600) ? 50 : 6;
            rst                 = ($urandom_range(0, 199) == 0);
            bus.id_reg1_addr    = 4'($urandom_range(0, 3));
            bus.id_reg2_addr    = 4'($urandom_range(0, 3));
            bus.ex_wb_addr      = 4'($urandom_range(0, 3));
            bus.id_reg1_read    = 1'($urandom_range(0, 1));
            bus.id_reg2_read    = 1'($urandom_range(0, 1));
            bus.ex_reg_write    = 1'($urandom_range(0, 1));
            bus.ex_is_load      = 1'($urandom_range(0, 1));
            bus.ex_branch_taken = ($urandom_range(0, 99) < 15);
            bus.mem_req         = ($urandom_range(0, 99) < 35);
            bus.mem_shared      = 1'($urandom_range(0, 1));
            bus.mem_ack         = ($urandom_range(0, 99) < ack_pct);
            bus.perf_clr        = ($urandom_range(0, 99) < 3);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline. It sits beside the forwarding unit and covers the hazards forwarding cannot resolve:
- load-use in ID;
- EX-stage taken branches;
- multi-cycle and shared-RAM data accesses in MEM, where the RAM is shared with instruction fetch.

It drives the hold/bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also keeps a stall-cycle performance counter.

Parameters:
REG_ADDR_W, 4, register address width; the encoding includes SP, IH and T, so those are compared like general registers.
TIMEOUT_CYCLES, 15, maximum MEM_WAIT cycles before a forced release.
WAIT_CNT_W, 4, width of the wait counter; must satisfy 2^WAIT_CNT_W >= TIMEOUT_CYCLES.
CNT_W, 16, stall counter width.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous active-high reset.
id_reg1_addr  in  REG_ADDR_W  ID operand-1 source register.
id_reg1_read  in  1  ID instruction actually reads operand 1.
id_reg2_addr  in  REG_ADDR_W  ID operand-2 source register.
id_reg2_read  in  1  ID instruction actually reads operand 2.
ex_wb_addr  in  REG_ADDR_W  EX destination register.
ex_reg_write  in  1  EX instruction writes a register.
ex_is_load  in  1  EX instruction is a memory load.
ex_branch_taken  in  1  EX resolved a taken branch or jump.
mem_req  in  1  MEM instruction accesses data RAM this cycle.
mem_shared  in  1  that access targets the RAM shared with fetch.
mem_ack  in  1  RAM controller completes the access this cycle.
perf_clr  in  1  clear stall_count.
pc_stall  out  1  hold PC.
ifid_stall  out  1  hold IF/ID.
ifid_flush  out  1  load NOP into IF/ID.
idex_stall  out  1  hold ID/EX.
idex_flush  out  1  load NOP into ID/EX.
exmem_stall  out  1  hold EX/MEM.
memwb_flush  out  1  load NOP into MEM/WB.
mem_timeout  out  1  one-cycle pulse on forced release.
stall_count  out  CNT_W  cycles with pc_stall=1, saturating.
ctrl_state  out  2  FSM state: 00 IDLE, 01 MEM_WAIT, 10 TIMEOUT.

Behaviour:
- All stall/flush outputs are combinational from the current state and inputs, so there is zero-cycle reaction. State and counters are registered.
- While rst=1, every stall/flush output and mem_timeout is 0.
- On a clock edge with rst=1: state becomes IDLE, wait_cnt=0, stall_count=0. Reset in the middle of MEM_WAIT returns to IDLE with no timeout pulse.
- Load-use condition: loaduse = ex_is_load & ex_reg_write & ((id_reg1_read & ex_wb_addr==id_reg1_addr) | (id_reg2_read & ex_wb_addr==id_reg2_addr)).
- Freeze output set: pc_stall=ifid_stall=idex_stall=exmem_stall=1, memwb_flush=1, ifid_flush=idex_flush=0.
- IDLE, mem_req=1 and mem_ack=0: freeze; next state MEM_WAIT with wait_cnt=0. Branch and load-use are not evaluated this cycle.
- IDLE otherwise: completion rules, applied in priority order:
  - ex_branch_taken: ifid_flush=1, idex_flush=1, pc_stall=0 so PC loads the target. Load-use and the shared-fetch loss are ignored, because the fetched instruction is squashed.
  - else loaduse: pc_stall=1, ifid_stall=1, idex_flush=1, one cycle only. The load moves to MEM and forwarding covers the dependency.
  - else mem_req & mem_ack & mem_shared: pc_stall=1, ifid_flush=1, because fetch lost the bus.
  - ifid_stall always overrides the shared-access ifid_flush.
  - All other outputs are 0.
- MEM_WAIT, mem_ack=0:
  - Freeze outputs; wait_cnt increments; ex_branch_taken is ignored, since the branch is held in EX.
  - If wait_cnt==TIMEOUT_CYCLES-1, the next state is TIMEOUT.
- MEM_WAIT, mem_ack=1: apply the IDLE completion rules this cycle; next state IDLE.
- TIMEOUT: freeze outputs except exmem_stall=0, releasing the access; mem_timeout=1; next state IDLE.
- stall_count:
  - perf_clr clears it to 0 and takes precedence over increment.
  - Otherwise it increments each cycle with pc_stall=1.
  - It holds at all-ones.
- Unused state 11 goes to IDLE on the next edge, with outputs as IDLE.

Test Plan:
1. Load-use hit: ex_is_load=1, ex_reg_write=1, ex_wb_addr=3, id_reg1_addr=3, id_reg1_read=1 for one cycle -> pc_stall=ifid_stall=idex_flush=1 that cycle only; stall_count 0->1. Repeat with id_reg1_read=0 -> all outputs 0, count unchanged.
2. Branch beats load-use: the load-use hit of test 1 plus ex_branch_taken=1 -> ifid_flush=1, idex_flush=1, pc_stall=0, ifid_stall=0.
3. Multi-cycle shared access: mem_req=1 and mem_shared=1 from cycle 0, mem_ack=1 on cycle 3 ->
   - cycles 0-2: freeze;
   - ctrl_state=01 for cycles 1-3;
   - cycle 3: pc_stall=1, ifid_flush=1, exmem_stall=0, memwb_flush=0;
   - stall_count +4;
   - state 00 on cycle 4.
4. Timeout: mem_req=1 held, mem_ack=0 ->
   - 15 cycles of MEM_WAIT;
   - then 1 cycle with ctrl_state=10, mem_timeout=1, exmem_stall=0;
   - then IDLE;
   - stall_count +17.
5. Reset and clear: rst=1 at the 5th MEM_WAIT cycle -> outputs 0 during reset, IDLE and stall_count=0 after the edge, no mem_timeout. perf_clr=1 together with pc_stall=1 -> stall_count=0 next cycle.
6. Single-cycle non-shared access: mem_req=1, mem_ack=1, mem_shared=0 in IDLE -> all outputs 0, state stays 00.
